// File: rtl/multisim_sched_pkg.sv
// ----------------------------------------------------------------------------
// multisim_sched_pkg
// Shared definitions for the multisim pull/push scheduler:
//   sched_state_e        - scheduler FSM states
//   DEF_DELAY_ACTIVE     - default backoff reload after a poll hit
//   DEF_DELAY_INACTIVE   - default backoff ceiling after poll misses
//   next_inactive_delay  - backoff growth rule applied on a poll miss
// ----------------------------------------------------------------------------
package multisim_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POLL,
        DELIVER,
        PUSH_WAIT
    } sched_state_e;

    localparam int DEF_DELAY_ACTIVE   = 2;
    localparam int DEF_DELAY_INACTIVE = 5;

    // Backoff after a miss: a cold channel starts at 1, otherwise the delay
    // quadruples up to the ceiling. The shift is done in 64 bits so a large
    // ceiling cannot wrap before the clamp is applied.
    function automatic int next_inactive_delay(input int d, input int delay_ceil);
        longint wide;
        if (d <= 0) return 1;
        wide = longint'(d) <<< 2;
        return (wide > longint'(delay_ceil)) ? delay_ceil : int'(wide);
    endfunction

endpackage

// File: rtl/multisim_pull_push_sched_if.sv
// ----------------------------------------------------------------------------
// multisim_pull_push_sched_if
// Bundles the per-channel client handshakes and the single DPI server port.
//   master : scheduler side (drives pull beats, push ready, server strobes)
//   slave  : environment side (clients and server bridge)
// Client signals:
//   ch_req, pull_data_vld, pull_data, push_data_rdy, push_data_vld, push_data
// Server signals:
//   srv_poll_vld, srv_ch, srv_result_vld, srv_result_data, srv_push_vld,
//   srv_push_data
// ----------------------------------------------------------------------------
interface multisim_pull_push_sched_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) ();

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        pull_data_vld;
    logic [DATA_W-1:0]        pull_data;
    logic [NUM_CH-1:0]        push_data_rdy;
    logic [NUM_CH-1:0]        push_data_vld;
    logic [NUM_CH*DATA_W-1:0] push_data;

    logic                     srv_poll_vld;
    logic [CH_W-1:0]          srv_ch;
    logic                     srv_result_vld;
    logic [DATA_W-1:0]        srv_result_data;
    logic                     srv_push_vld;
    logic [DATA_W-1:0]        srv_push_data;

    modport master (
        input  ch_req, push_data_vld, push_data, srv_result_vld, srv_result_data,
        output pull_data_vld, pull_data, push_data_rdy,
               srv_poll_vld, srv_ch, srv_push_vld, srv_push_data
    );

    modport slave (
        output ch_req, push_data_vld, push_data, srv_result_vld, srv_result_data,
        input  pull_data_vld, pull_data, push_data_rdy,
               srv_poll_vld, srv_ch, srv_push_vld, srv_push_data
    );

endinterface

// File: rtl/multisim_rr_arbiter.sv
// ----------------------------------------------------------------------------
// multisim_rr_arbiter
// Combinational round-robin picker: the first eligible channel at or after
// ptr (wrapping) wins.
//   eligible   in  NUM_CH : channels that may be granted
//   ptr        in  CH_W   : highest-priority channel index
//   gnt_onehot out NUM_CH : one-hot grant
//   gnt_idx    out CH_W   : grant index
//   any_vld    out 1      : at least one channel eligible
// ----------------------------------------------------------------------------
module multisim_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any_vld
);

    logic [CH_W-1:0] cand;

    // Scan from the lowest priority upwards so the last hit, which is the
    // one closest to ptr, overrides the earlier ones without a loop break.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_vld    = 1'b0;
        cand       = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            cand = CH_W'((int'(ptr) + off) % NUM_CH);
            if (eligible[cand]) begin
                gnt_onehot       = '0;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
                any_vld          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multisim_pull_push_sched.sv
// ----------------------------------------------------------------------------
// multisim_pull_push_sched
// Time-shares one multisim DPI server port among NUM_CH pull-then-push
// client channels. A granted channel is polled; on a hit the pulled beat is
// handed to the client, the client's push beat is awaited and forwarded to
// the server. Misses grow a per-channel backoff that keeps the channel
// ineligible for a while.
//   clk    in : clock
//   rst    in : synchronous active-high reset
//   enable in : permits new grants (in-flight transactions always finish)
//   bus       : client handshakes and server port (master modport)
// ----------------------------------------------------------------------------
module multisim_pull_push_sched
    import multisim_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 8,
    parameter int DELAY_ACTIVE   = DEF_DELAY_ACTIVE,
    parameter int DELAY_INACTIVE = DEF_DELAY_INACTIVE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    multisim_pull_push_sched_if.master    bus
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DLY_MX = (DELAY_ACTIVE > DELAY_INACTIVE) ? DELAY_ACTIVE : DELAY_INACTIVE;
    localparam int BO_W   = $clog2(DLY_MX) + 1;

    sched_state_e      state;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   gnt;
    logic [NUM_CH-1:0] gnt_oh;
    logic [BO_W-1:0]   bo  [NUM_CH];
    logic [BO_W-1:0]   dly [NUM_CH];
    logic [BO_W-1:0]   bo_next;

    logic [NUM_CH-1:0] pull_vld_q;
    logic [DATA_W-1:0] pull_data_q;
    logic [NUM_CH-1:0] push_rdy_q;
    logic              poll_vld_q;
    logic              push_vld_q;
    logic [DATA_W-1:0] push_data_q;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] arb_oh;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] push_slice [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i]   = bus.ch_req[i] && (dly[i] == '0);
            push_slice[i] = bus.push_data[i*DATA_W +: DATA_W];
        end
    end

    assign bo_next = BO_W'(next_inactive_delay(int'(bo[gnt]), DELAY_INACTIVE));

    multisim_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .eligible   (eligible),
        .ptr        (ptr),
        .gnt_onehot (arb_oh),
        .gnt_idx    (arb_idx),
        .any_vld    (arb_any)
    );

    // NOTE: sequential state uses non-blocking assignments only; the later dly[gnt] load deliberately overrides the free-running decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            gnt_oh      <= '0;
            pull_vld_q  <= '0;
            pull_data_q <= '0;
            push_rdy_q  <= '0;
            poll_vld_q  <= 1'b0;
            push_vld_q  <= 1'b0;
            push_data_q <= '0;
            // NOTE: the backoff arrays are a handful of flops, not RAM, and must restart cold, so they are reset.
            for (int i = 0; i < NUM_CH; i++) begin
                bo[i]  <= '0;
                dly[i] <= '0;
            end
        end else begin
            push_vld_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (dly[i] != '0) dly[i] <= dly[i] - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable && arb_any) begin
                        gnt        <= arb_idx;
                        gnt_oh     <= arb_oh;
                        ptr        <= (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
                        poll_vld_q <= 1'b1;
                        state      <= POLL;
                    end
                end
                POLL: begin
                    poll_vld_q <= 1'b0;
                    if (bus.srv_result_vld) begin
                        pull_vld_q  <= gnt_oh;
                        pull_data_q <= bus.srv_result_data;
                        bo[gnt]     <= BO_W'(DELAY_ACTIVE);
                        dly[gnt]    <= BO_W'(DELAY_ACTIVE);
                        state       <= DELIVER;
                    end else begin
                        bo[gnt]  <= bo_next;
                        dly[gnt] <= bo_next;
                        state    <= IDLE;
                    end
                end
                DELIVER: begin
                    pull_vld_q <= '0;
                    push_rdy_q <= gnt_oh;
                    state      <= PUSH_WAIT;
                end
                PUSH_WAIT: begin
                    // Push valid is only looked at here, so a client that
                    // raises it early simply waits for ready.
                    if (bus.push_data_vld[gnt]) begin
                        push_rdy_q  <= '0;
                        push_vld_q  <= 1'b1;
                        push_data_q <= push_slice[gnt];
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pull_data_vld = pull_vld_q;
    assign bus.pull_data     = pull_data_q;
    assign bus.push_data_rdy = push_rdy_q;
    assign bus.srv_poll_vld  = poll_vld_q;
    assign bus.srv_ch        = gnt;
    assign bus.srv_push_vld  = push_vld_q;
    assign bus.srv_push_data = push_data_q;

endmodule
